pattern_seq_detector: RTL and testbench

PATTERN_SEQ_DETECTOR -- requirements
Module: pattern_seq_detector

---
 rtl/seq_det_pkg.sv | 12 +
 rtl/pattern_seq_detector_if.sv | 18 +
 rtl/pattern_seq_detector_reg.sv | 16 +
 rtl/pattern_seq_detector.sv | 55 +++++
 tb/tb_pattern_seq_detector.sv | 136 +++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: default constants and the clog2 helper for pattern_seq_detector
package seq_det_pkg;
  localparam int DEF_PAT_W = 3;
  localparam logic [2:0] DEF_PATTERN = 3'b111;
  localparam int DEF_CNT_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pattern_seq_detector_if.sv
// pattern_seq_detector_if: detector bus
//   master drives en, x, overlap; slave drives y, fill, hist, match_cnt
interface pattern_seq_detector_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) ();
  logic en;
  logic x;
  logic overlap;
  logic y;
  logic [clog2(PAT_W)-1:0] fill;
  logic [PAT_W-2:0] hist;
  logic [CNT_W-1:0] match_cnt;
  modport master (output en, x, overlap, input y, fill, hist, match_cnt);
  modport slave (input en, x, overlap, output y, fill, hist, match_cnt);
endinterface

// File: rtl/pattern_seq_detector_reg.sv
// seq_det_reg: W-bit register with synchronous active-high reset and load enable
//   clk, rst: clock and reset; i_ld: load i_d; o_q: stored value
module seq_det_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk)
    r_q <= rst ? '0 : i_ld ? i_d : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/pattern_seq_detector.sv
// pattern_seq_detector: serial PATTERN detector with Mealy match flag and optional match counter
//   clk, rst: clock and synchronous active-high reset
//   bus (slave): en, x, overlap in; y, fill, hist, match_cnt out
//   SEQ_DET_MATCH_CNT_EN: when defined, builds the saturating match counter; otherwise match_cnt is 0
module pattern_seq_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  pattern_seq_detector_if.slave bus
);
  localparam int FILL_W = clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);
  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("pattern_seq_detector: PAT_W must be in 2..16");
  end
  logic [PAT_W-2:0]  w_hist, w_hist_d;
  logic [FILL_W-1:0] w_fill, w_fill_d;
  logic [CNT_W-1:0]  w_cnt;
  logic [PAT_W-1:0]  w_shift;
  logic              w_y, w_clr;
  // history with the current bit appended: compare window and next history in one
  assign w_shift  = {w_hist, bus.x};
  assign w_y      = ~rst & bus.en & (w_fill == FULL) & (w_shift == PATTERN);
  // non-overlapping mode throws the whole history away after a match
  assign w_clr    = w_y & ~bus.overlap;
  assign w_hist_d = w_clr ? '0 : w_shift[PAT_W-2:0];
  assign w_fill_d = w_clr ? '0 : (w_fill == FULL) ? w_fill : w_fill + 1'b1;
  seq_det_reg #(.W(PAT_W-1)) u_hist (
    .clk(clk), .rst(rst), .i_ld(bus.en), .i_d(w_hist_d), .o_q(w_hist)
  );
  seq_det_reg #(.W(FILL_W)) u_fill (
    .clk(clk), .rst(rst), .i_ld(bus.en), .i_d(w_fill_d), .o_q(w_fill)
  );
`ifdef SEQ_DET_MATCH_CNT_EN
  logic w_cnt_ld;
  logic [CNT_W-1:0] w_cnt_d;
  // counting stops once all ones is reached
  assign w_cnt_ld = w_y & ~&w_cnt;
  assign w_cnt_d  = w_cnt + 1'b1;
  seq_det_reg #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .i_ld(w_cnt_ld), .i_d(w_cnt_d), .o_q(w_cnt)
  );
`else
  assign w_cnt = '0;
`endif
  assign bus.y         = w_y;
  assign bus.fill      = w_fill;
  assign bus.hist      = w_hist;
  assign bus.match_cnt = w_cnt;
endmodule

// File: tb/tb_pattern_seq_detector.sv
// tb_pattern_seq_detector: table-driven scoreboard bench for pattern_seq_detector
module tb_pattern_seq_detector;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pattern_seq_detector_if #(.PAT_W(3), .CNT_W(8)) b3 ();
  pattern_seq_detector_if #(.PAT_W(4), .CNT_W(8)) b4 ();
  pattern_seq_detector_if #(.PAT_W(3), .CNT_W(2)) b2 ();
  pattern_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_d3 (.clk(clk), .rst(rst), .bus(b3));
  pattern_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_d4 (.clk(clk), .rst(rst), .bus(b4));
  pattern_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(2)) u_d2 (.clk(clk), .rst(rst), .bus(b2));
  typedef struct packed {
    logic r, e, x, o, y;
    logic [1:0] fill, hist;
    logic [7:0] cnt;
  } vec_t;
  typedef struct {
    int id;
    int dut;
    logic y;
    logic [3:0] fill;
    logic [15:0] hist;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];
  int tests = 0, fails = 0, step_no = 0;
  int y4[7] = '{0, 0, 0, 1, 0, 0, 1};
  int f4[7] = '{0, 1, 2, 3, 3, 3, 3};
  int h4[7] = '{0, 1, 2, 5, 3, 6, 5};
  int c4[7] = '{0, 0, 0, 0, 1, 1, 1};
  int x4[7] = '{1, 0, 1, 1, 0, 1, 1};
  int y2[7] = '{0, 0, 1, 1, 1, 1, 1};
  int f2[7] = '{0, 1, 2, 2, 2, 2, 2};
  int h2[7] = '{0, 1, 3, 3, 3, 3, 3};
  int c2[7] = '{0, 0, 0, 1, 2, 3, 3};
  function automatic vec_t v(logic r, e, x, o, y, logic [1:0] f, h, logic [7:0] c);
    return '{r, e, x, o, y, f, h, c};
  endfunction
  task automatic chk(string nm, int id, logic [15:0] a, logic [15:0] ex);
    tests++;
    if (a !== ex) begin
      fails++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, a, ex);
    end
  endtask
  task automatic compare();
    exp_t e;
    logic ay;
    logic [3:0] af;
    logic [15:0] ah;
    logic [7:0] ac;
    e = sb.pop_front();
    case (e.dut)
      0: begin ay = b3.y; af = 4'(b3.fill); ah = 16'(b3.hist); ac = 8'(b3.match_cnt); end
      1: begin ay = b4.y; af = 4'(b4.fill); ah = 16'(b4.hist); ac = 8'(b4.match_cnt); end
      default: begin ay = b2.y; af = 4'(b2.fill); ah = 16'(b2.hist); ac = 8'(b2.match_cnt); end
    endcase
    chk("y", e.id, 16'(ay), 16'(e.y));
    chk("fill", e.id, 16'(af), 16'(e.fill));
    chk("hist", e.id, ah, e.hist);
    chk("match_cnt", e.id, 16'(ac), 16'(e.cnt));
  endtask
  task automatic step(int d, logic r, e, xx, o, logic ey, logic [3:0] ef, logic [15:0] eh, logic [7:0] ec);
    @(negedge clk);
    rst = r;
    b3.en = 1'b0; b4.en = 1'b0; b2.en = 1'b0;
    case (d)
      0: begin b3.en = e; b3.x = xx; b3.overlap = o; end
      1: begin b4.en = e; b4.x = xx; b4.overlap = o; end
      default: begin b2.en = e; b2.x = xx; b2.overlap = o; end
    endcase
    step_no++;
    sb.push_back('{step_no, d, ey, ef, eh, CE ? ec : 8'd0});
    #2 compare();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    b3.en = 0; b3.x = 0; b3.overlap = 0;
    b4.en = 0; b4.x = 0; b4.overlap = 0;
    b2.en = 0; b2.x = 0; b2.overlap = 0;
    // seven ones, non-overlapping: matches on 3 and 6, then reset
    for (int i = 0; i < 7; i++)
      tbl.push_back(v(0, 1, 1, 0, (i == 2 || i == 5), 2'(i % 3), (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd1 : 2'd3, 8'(i / 3)));
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 2));
    // seven ones, overlapping: matches on 3..7, then reset
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 1, 1, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0, 1, 1, 1, 1, 2, 3, 8'(i)));
    tbl.push_back(v(1, 0, 0, 0, 0, 2, 3, 5));
    // two ones, two idle cycles, then the completing one
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 2, 3, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 2, 3, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 2, 3, 0));
    // reset mid-pattern (would have matched), restart from empty, idle with x=1
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 2, 3, 1));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 2, 3, 0));
    tbl.push_back(v(0, 1, 1, 0, 1, 2, 3, 0));
    // a zero breaks the run; overlap dropped in the matching cycle clears history
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(v(0, 1, 1, 1, 0, 2, 2, 1));
    tbl.push_back(v(0, 1, 1, 1, 0, 2, 1, 1));
    tbl.push_back(v(0, 1, 1, 0, 1, 2, 3, 1));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 2));
    repeat (2) @(negedge clk);
    foreach (tbl[i])
      step(0, tbl[i].r, tbl[i].e, tbl[i].x, tbl[i].o, tbl[i].y, 4'(tbl[i].fill), 16'(tbl[i].hist), tbl[i].cnt);
    // PAT_W=4, PATTERN=1011, overlapping stream 1011011
    for (int i = 0; i < 7; i++)
      step(1, 0, 1, x4[i][0], 1, y4[i][0], 4'(f4[i]), 16'(h4[i]), 8'(c4[i]));
    step(1, 0, 0, 0, 1, 0, 4'd3, 16'd3, 8'd2);
    // CNT_W=2: five matches saturate at 3
    for (int i = 0; i < 7; i++)
      step(2, 0, 1, 1, 1, y2[i][0], 4'(f2[i]), 16'(h2[i]), 8'(c2[i]));
    step(2, 0, 0, 0, 1, 0, 4'd2, 16'd3, 8'd3);
    chk("scoreboard_empty", step_no, 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
